// File: rtl/ysyx_220053_pkg.sv
// Shared types and constants for the IDU: ALU operation codes, RV64I opcodes
// and the decoded bundle carried from decode to execute.
package ysyx_220053_pkg;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0]  OPC_OP_IMM  = 7'h13;
    localparam logic [6:0]  OPC_OP      = 7'h33;
    localparam logic [6:0]  OPC_LUI     = 7'h37;
    localparam logic [6:0]  OPC_SYSTEM  = 7'h73;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            wen;
        logic            alu_src_b;
        alu_op_e         alu_op;
        logic [XLEN-1:0] imm;
        logic            ebreak;
        logic            illegal;
    } idu_bundle_t;

endpackage

// File: rtl/ysyx_220053_if.sv
// Fetch-side and execute-side handshake of the IDU; slave is the IDU itself.
interface ysyx_220053_if;
    import ysyx_220053_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst_i;
    logic [XLEN-1:0] pc_i;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc_o;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            wen;
    logic            ALUSrcB;
    logic [3:0]      ALUOp;
    logic [XLEN-1:0] imm;
    logic            ebreak;
    logic            illegal;

    modport slave (
        input  in_valid, inst_i, pc_i, out_ready,
        output in_ready, out_valid, pc_o, rd, rs1, rs2, wen, ALUSrcB, ALUOp,
               imm, ebreak, illegal
    );

    modport master (
        output in_valid, inst_i, pc_i, out_ready,
        input  in_ready, out_valid, pc_o, rd, rs1, rs2, wen, ALUSrcB, ALUOp,
               imm, ebreak, illegal
    );

endinterface

// File: rtl/ysyx_220053_decoder.sv
// Combinational RV64I subset decoder: instruction word to EXU control bundle.
// The pc field is left zero; the queue owner fills it in.
module ysyx_220053_decoder
    import ysyx_220053_pkg::*;
(
    input  logic [31:0] inst,
    output idu_bundle_t bundle
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    logic            legal;
    logic            is_ebreak;
    logic            src_b;
    alu_op_e         op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};

    always_comb begin
        legal     = 1'b0;
        is_ebreak = 1'b0;
        src_b     = 1'b0;
        op        = ALU_ADD;
        imm       = '0;
        rs1       = inst[19:15];
        case (opcode)
            OPC_OP_IMM: begin
                legal = 1'b1;
                src_b = 1'b1;
                imm   = imm_i;
                case (funct3)
                    3'b000: op = ALU_ADD;
                    3'b001: begin
                        op    = ALU_SLL;
                        legal = (inst[31:26] == 6'b000000);
                    end
                    3'b010: op = ALU_SLT;
                    3'b011: op = ALU_SLTU;
                    3'b100: op = ALU_XOR;
                    3'b101: begin
                        op    = inst[30] ? ALU_SRA : ALU_SRL;
                        legal = (inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000);
                    end
                    3'b110: op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                legal = (funct7 == 7'b0000000);
                case (funct3)
                    3'b000: begin
                        op = ALU_ADD;
                        if (funct7 == 7'b0100000) begin
                            op    = ALU_SUB;
                            legal = 1'b1;
                        end
                    end
                    3'b001: op = ALU_SLL;
                    3'b010: op = ALU_SLT;
                    3'b011: op = ALU_SLTU;
                    3'b100: op = ALU_XOR;
                    3'b101: begin
                        op = ALU_SRL;
                        if (funct7 == 7'b0100000) begin
                            op    = ALU_SRA;
                            legal = 1'b1;
                        end
                    end
                    3'b110: op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1;
                rs1   = 5'd0;
                src_b = 1'b1;
                imm   = imm_u;
            end
            OPC_SYSTEM: begin
                if (inst == EBREAK_INST) begin
                    legal     = 1'b1;
                    is_ebreak = 1'b1;
                end
            end
            default: ;
        endcase
        // Illegal words still travel down the pipe, but as a harmless no-op
        if (!legal) begin
            op    = ALU_ADD;
            src_b = 1'b0;
            imm   = '0;
        end
    end

    always_comb begin
        bundle           = '0;
        bundle.rd        = inst[11:7];
        bundle.rs1       = rs1;
        bundle.rs2       = inst[24:20];
        bundle.wen       = legal && !is_ebreak && (inst[11:7] != 5'd0);
        bundle.alu_src_b = src_b;
        bundle.alu_op    = op;
        bundle.imm       = imm;
        bundle.ebreak    = is_ebreak;
        bundle.illegal   = !legal;
    end

endmodule

// File: rtl/ysyx_220053_idu.sv
// Decode stage: combinational decode into a two-entry bundle queue so fetch
// and execute can each move one instruction per cycle.
module ysyx_220053_idu
    import ysyx_220053_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    ysyx_220053_if.slave   bus
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    idu_bundle_t dec;
    idu_bundle_t entry;
    idu_bundle_t head;
    idu_bundle_t mem [0:DEPTH-1];

    logic       head_ptr;
    logic       tail_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    ysyx_220053_decoder u_decoder (
        .inst   (bus.inst_i),
        .bundle (dec)
    );

    always_comb begin
        entry    = dec;
        entry.pc = bus.pc_i;
    end

    // in_ready comes only from the registered count, never from out_ready
    assign bus.in_ready  = (count < FULL_CNT);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count    <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail_ptr] <= entry;
                tail_ptr      <= ~tail_ptr;
            end
            if (pop) begin
                head_ptr <= ~head_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = bus.out_valid ? mem[head_ptr] : '0;

    assign bus.pc_o    = head.pc;
    assign bus.rd      = head.rd;
    assign bus.rs1     = head.rs1;
    assign bus.rs2     = head.rs2;
    assign bus.wen     = head.wen;
    assign bus.ALUSrcB = head.alu_src_b;
    assign bus.ALUOp   = head.alu_op;
    assign bus.imm     = head.imm;
    assign bus.ebreak  = head.ebreak;
    assign bus.illegal = head.illegal;

endmodule

// File: tb/tb_ysyx_220053_idu.sv
// Directed and randomized bench for the IDU against a queue-based reference model.
module tb_ysyx_220053_idu;

    localparam int N_RAND = 1000;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                           A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                           A_OR = 4'd8, A_AND = 4'd9;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wen;
        logic        srcb;
        logic [3:0]  op;
        logic [63:0] imm;
        logic        eb;
        logic        il;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ysyx_220053_if bus();

    ysyx_220053_idu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   pops = 0;
    logic last_accept = 1'b0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the instruction-set rules
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
        exp_t e;
        logic [3:0] by_f3 [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        logic legal = 1'b0;
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        e = '0;
        e.pc  = pc;
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.op  = A_ADD;
        if (w[6:0] == 7'h13) begin
            e.srcb = 1'b1;
            e.imm  = {{52{w[31]}}, w[31:20]};
            e.op   = by_f3[f3];
            if (f3 == 3'd1)      legal = (w[31:26] == 6'h00);
            else if (f3 == 3'd5) begin
                legal = (w[31:26] == 6'h00) || (w[31:26] == 6'h10);
                if (w[30]) e.op = A_SRA;
            end
            else                 legal = 1'b1;
        end else if (w[6:0] == 7'h33) begin
            e.op  = by_f3[f3];
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            if (f7 == 7'h20 && f3 == 3'd0) e.op = A_SUB;
            if (f7 == 7'h20 && f3 == 3'd5) e.op = A_SRA;
        end else if (w[6:0] == 7'h37) begin
            legal  = 1'b1;
            e.rs1  = 5'd0;
            e.srcb = 1'b1;
            e.imm  = {{32{w[31]}}, w[31:12], 12'h000};
        end else if (w == 32'h0010_0073) begin
            legal = 1'b1;
            e.eb  = 1'b1;
        end
        if (!legal) begin
            e.op   = A_ADD;
            e.srcb = 1'b0;
            e.imm  = '0;
        end
        e.il  = !legal;
        e.wen = legal && !e.eb && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o = {bus.pc_o, bus.rd, bus.rs1, bus.rs2, bus.wen, bus.ALUSrcB, bus.ALUOp,
             bus.imm, bus.ebreak, bus.illegal};
        return o;
    endfunction

    function automatic logic [5:0] pick6();
        int r = $urandom_range(0, 2);
        logic [5:0] v = 6'($urandom);
        if (r == 0) v = 6'h00;
        if (r == 1) v = 6'h10;
        return v;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w = $urandom;
        int kind = $urandom_range(0, 6);
        if (kind <= 1) begin
            w[6:0] = 7'h13;
            if (w[14:12] == 3'd5) w[31:26] = pick6();
            if (w[14:12] == 3'd1) begin
                w[31:26] = pick6();
                if (w[31:26] == 6'h10) w[31:26] = 6'h00;
            end
        end else if (kind <= 3) begin
            w[6:0]   = 7'h33;
            w[31:26] = pick6();
            w[25]    = ($urandom_range(0, 3) == 0);
        end else if (kind == 4) begin
            w[6:0] = 7'h37;
        end else if (kind == 5) begin
            if ($urandom_range(0, 1) == 1) w = 32'h0010_0073;
            else                           w[6:0] = 7'h73;
        end
        return w;
    endfunction

    // One clock: check outputs against the model head, drive inputs, advance the model
    task automatic cycle(input logic v, input logic [31:0] w, input logic [63:0] pc,
                         input logic ordy);
        exp_t o;
        exp_t e;
        logic accept;
        chk("out_valid", bus.out_valid, q.size() != 0);
        chk("in_ready", bus.in_ready, q.size() < 2);
        if (q.size() != 0) begin
            o = observe();
            e = q[0];
            if (e.eb) begin
                o.op = 4'd0; o.srcb = 1'b0; o.imm = '0;
                e.op = 4'd0; e.srcb = 1'b0; e.imm = '0;
            end
            chk("bundle", o, e);
        end
        bus.in_valid  = v;
        bus.inst_i    = w;
        bus.pc_i      = pc;
        bus.out_ready = ordy;
        accept = v && (q.size() < 2);
        if (ordy && q.size() != 0) begin
            void'(q.pop_front());
            pops++;
        end
        if (accept) q.push_back(ref_decode(w, pc));
        last_accept = accept;
        @(negedge clk);
    endtask

    task automatic present(input logic [31:0] w);
        cycle(1'b1, w, 64'h8000_0000 + 64'(w[11:0]), 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        cycle(1'b0, 32'h0, 64'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] bp [4] = '{32'h0050_0093, 32'h0020_8133, 32'h0030_C193, 32'h1234_5237};
        int   k;
        int   c;
        int   sent;
        int   pops0;
        logic v;

        bus.in_valid  = 1'b0;
        bus.inst_i    = '0;
        bus.pc_i      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", bus.out_valid, 1'b0);
        chk("rst.in_ready", bus.in_ready, 1'b1);
        chk("rst.pc_o", bus.pc_o, 64'h0);
        chk("rst.imm", bus.imm, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        present(32'h02A0_0293);
        chk("addi.valid", bus.out_valid, 1'b1);
        chk("addi.rd", bus.rd, 5'd5);
        chk("addi.rs1", bus.rs1, 5'd0);
        chk("addi.wen", bus.wen, 1'b1);
        chk("addi.srcb", bus.ALUSrcB, 1'b1);
        chk("addi.op", bus.ALUOp, A_ADD);
        chk("addi.imm", bus.imm, 64'd42);
        drain();

        present(32'h4020_81B3);
        chk("sub.rd", bus.rd, 5'd3);
        chk("sub.rs1", bus.rs1, 5'd1);
        chk("sub.rs2", bus.rs2, 5'd2);
        chk("sub.op", bus.ALUOp, A_SUB);
        chk("sub.srcb", bus.ALUSrcB, 1'b0);
        chk("sub.wen", bus.wen, 1'b1);
        drain();

        present(32'h43F3_D393);
        chk("srai.op", bus.ALUOp, A_SRA);
        chk("srai.imm", bus.imm, 64'h43F);
        drain();

        present(32'h8000_00B7);
        chk("lui.rs1", bus.rs1, 5'd0);
        chk("lui.imm", bus.imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui.op", bus.ALUOp, A_ADD);
        drain();

        present(32'h0010_0073);
        chk("ebreak.flag", bus.ebreak, 1'b1);
        chk("ebreak.wen", bus.wen, 1'b0);
        chk("ebreak.illegal", bus.illegal, 1'b0);
        drain();

        present(32'hFFFF_FFFF);
        chk("ones.illegal", bus.illegal, 1'b1);
        chk("ones.wen", bus.wen, 1'b0);
        chk("ones.op", bus.ALUOp, A_ADD);
        chk("ones.imm", bus.imm, 64'h0);
        drain();

        present(32'h0010_0013);
        chk("addi_x0.wen", bus.wen, 1'b0);
        drain();

        present(32'h4020_9133);
        chk("sll_f7.illegal", bus.illegal, 1'b1);
        drain();

        // Backpressure: four offers with the consumer stalled
        k = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, bp[k], 64'h1000 + 64'(k), 1'b0);
            if (last_accept) k++;
        end
        chk("bp.accepted", k, 2);
        chk("bp.in_ready", bus.in_ready, 1'b0);
        chk("bp.head_rd", bus.rd, 5'd1);
        pops0 = pops;
        c = 0;
        while ((k < 4 || q.size() != 0) && c < 50) begin
            cycle(k < 4, (k < 4) ? bp[k] : 32'h0, 64'h1000 + 64'(k), 1'b1);
            if (last_accept) k++;
            c++;
        end
        chk("bp.drained", pops - pops0, 4);

        // Random traffic with random backpressure
        sent = 0;
        pops0 = pops;
        c = 0;
        while ((sent < N_RAND || q.size() != 0) && c < 20000) begin
            v = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
            cycle(v, gen_inst(), {$urandom, $urandom}, $urandom_range(0, 1) == 1);
            if (last_accept) sent++;
            c++;
        end
        chk("rand.sent", sent, N_RAND);
        chk("rand.popped", pops - pops0, N_RAND);

        // Asynchronous reset with a full queue
        cycle(1'b1, 32'h0050_0093, 64'h2000, 1'b0);
        cycle(1'b1, 32'h0060_0113, 64'h2004, 1'b0);
        chk("rst_mid.full", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.out_valid", bus.out_valid, 1'b0);
        chk("rst_mid.in_ready", bus.in_ready, 1'b1);
        chk("rst_mid.pc_o", bus.pc_o, 64'h0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 32'h02A0_0293, 64'h3000, 1'b1);
        bus.in_valid = 1'b0;
        chk("rst_mid.latency", bus.out_valid, 1'b1);
        chk("rst_mid.pc", bus.pc_o, 64'h3000);
        drain();
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
